// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake states, word type and arbiter encodings.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT_D = 2'd1,
      ARB_GRANT_I = 2'd2
   } arbstate_t;

   // Core-index width; a single-core build still needs a 1-bit index.
   function automatic int arb_cpuid_w(input int cpus);
      return (cpus > 1) ? $clog2(cpus) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick
   import cpu_types_pkg::*;
#(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic         valid_o,
   output logic [W-1:0] idx_o
);

   logic [N-1:0] hit;
   logic [W-1:0] cand [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = W'((int'(ptr_i) + gi) % N);
      assign hit[gi]  = req_i[cand[gi]];
   end

   // Scan from the far end so the candidate nearest the pointer wins.
   always_comb begin
      valid_o = |hit;
      idx_o   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (hit[k]) idx_o = cand[k];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single RAM port among all icache/dcache requesters; D before I,
// round-robin across cores, grant held for a whole block with a fairness cap.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int CPUS       = 2,
   parameter int HOLD_LIMIT = 2
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic       [CPUS-1:0]  iREN,
   input  word_t      [CPUS-1:0]  iaddr,
   output logic       [CPUS-1:0]  iwait,
   output word_t      [CPUS-1:0]  iload,
   input  logic       [CPUS-1:0]  dREN,
   input  logic       [CPUS-1:0]  dWEN,
   input  word_t      [CPUS-1:0]  daddr,
   input  word_t      [CPUS-1:0]  dstore,
   output logic       [CPUS-1:0]  dwait,
   output word_t      [CPUS-1:0]  dload,
   output logic                   ramREN,
   output logic                   ramWEN,
   output word_t                  ramaddr,
   output word_t                  ramstore,
   input  word_t                  ramload,
   input  ramstate_t              ramstate
);

   localparam int ARB_CPUID_W = arb_cpuid_w(CPUS);
   localparam int HOLD_W      = $clog2(HOLD_LIMIT + 1);

   arbstate_t              state_q, state_d;
   logic [ARB_CPUID_W-1:0] owner_q, owner_d;
   logic [ARB_CPUID_W-1:0] rr_q, rr_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;

   logic [CPUS-1:0]        d_req, owner_oh;
   logic                   d_valid, i_valid;
   logic [ARB_CPUID_W-1:0] d_idx, i_idx, rr_next;
   logic                   access, owner_req, other_req, release_grant;
   logic [HOLD_W-1:0]      hold_next;

   assign d_req    = dREN | dWEN;
   assign access   = (ramstate == ACCESS);
   assign owner_oh = CPUS'(1) << owner_q;
   assign rr_next  = (owner_q == ARB_CPUID_W'(CPUS - 1)) ? '0 : owner_q + 1'b1;

   rr_pick #(.N(CPUS), .W(ARB_CPUID_W)) u_pick_d (
      .req_i   (d_req),
      .ptr_i   (rr_q),
      .valid_o (d_valid),
      .idx_o   (d_idx)
   );

   rr_pick #(.N(CPUS), .W(ARB_CPUID_W)) u_pick_i (
      .req_i   (iREN),
      .ptr_i   (rr_q),
      .valid_o (i_valid),
      .idx_o   (i_idx)
   );

   for (genvar gi = 0; gi < CPUS; gi++) begin : g_load
      assign iload[gi] = ramload;
      assign dload[gi] = ramload;
   end

   // The owner's own icache counts as a competitor while it holds a D grant, and vice versa.
   always_comb begin
      owner_req = 1'b0;
      other_req = 1'b0;
      case (state_q)
         ARB_GRANT_D: begin
            owner_req = |(d_req & owner_oh);
            other_req = (|(d_req & ~owner_oh)) | (|iREN);
         end
         ARB_GRANT_I: begin
            owner_req = |(iREN & owner_oh);
            other_req = (|(iREN & ~owner_oh)) | (|d_req);
         end
         default: ;
      endcase
   end

   assign hold_next = (access && hold_q != HOLD_W'(HOLD_LIMIT)) ? hold_q + 1'b1 : hold_q;
   assign release_grant = ~owner_req
                        | (access & other_req & (hold_next == HOLD_W'(HOLD_LIMIT)));

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      hold_d  = hold_q;
      case (state_q)
         ARB_IDLE: begin
            if (d_valid) begin
               state_d = ARB_GRANT_D;
               owner_d = d_idx;
            end else if (i_valid) begin
               state_d = ARB_GRANT_I;
               owner_d = i_idx;
            end
         end
         default: begin
            if (release_grant) begin
               state_d = ARB_IDLE;
               rr_d    = rr_next;
               hold_d  = '0;
            end else begin
               hold_d  = hold_next;
            end
         end
      endcase
   end

   // Address, data and waits pass straight through from the owner each cycle.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = '1;
      dwait    = '1;
      case (state_q)
         ARB_GRANT_D: begin
            ramaddr        = daddr[owner_q];
            ramWEN         = dWEN[owner_q];
            ramREN         = dREN[owner_q] & ~dWEN[owner_q];
            ramstore       = dstore[owner_q];
            dwait[owner_q] = ~access;
         end
         ARB_GRANT_I: begin
            ramaddr        = iaddr[owner_q];
            ramREN         = iREN[owner_q];
            iwait[owner_q] = ~access;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= ARB_IDLE;
         owner_q <= '0;
         rr_q    <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         hold_q  <= hold_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: behavioural RAM with programmable latency,
// expected completions queued in service order and checked as waits drop.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int CPUS       = 2;
   localparam int HOLD_LIMIT = 2;
   localparam int BUDGET     = 60;

   logic             CLK = 1'b0;
   logic             nRST;
   logic [CPUS-1:0]  iREN, iwait, dREN, dWEN, dwait;
   word_t [CPUS-1:0] iaddr, iload, daddr, dstore, dload;
   logic             ramREN, ramWEN;
   word_t            ramaddr, ramstore, ramload;
   ramstate_t        ramstate;

   int   lat;
   int   busy_cnt;
   logic use_ovr;

   typedef struct packed {
      logic       is_d;
      logic       wr;
      logic [7:0] core;
      word_t      addr;
      word_t      data;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   mem_arbiter #(.CPUS(CPUS), .HOLD_LIMIT(HOLD_LIMIT)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   // RAM model: BUSY for lat cycles after an enable appears, then one ACCESS.
   always @(posedge CLK or negedge nRST) begin
      if (!nRST)                                      busy_cnt <= 0;
      else if ((ramREN | ramWEN) && ramstate != ACCESS) busy_cnt <= busy_cnt + 1;
      else                                            busy_cnt <= 0;
   end

   always_comb begin
      ramstate = FREE;
      if (ramREN | ramWEN) ramstate = (busy_cnt >= lat) ? ACCESS : BUSY;
   end

   function automatic word_t rd_data(input word_t a);
      return a ^ 32'h5A5A_0000;
   endfunction

   assign ramload = use_ovr ? 32'hDEAD_BEEF : rd_data(ramaddr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic is_d, input logic wr, input int core,
                               input word_t addr, input word_t data);
      exp_t e;
      e.is_d = is_d;
      e.wr   = wr;
      e.core = 8'(core);
      e.addr = addr;
      e.data = data;
      return e;
   endfunction

   task automatic complete(input logic is_d, input int c);
      exp_t  e;
      word_t obs_data;
      check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      check("who", 32'({is_d, 8'(c)}), 32'({e.is_d, e.core}));
      check("addr", ramaddr, e.addr);
      obs_data = e.wr ? ramstore : (is_d ? dload[c] : iload[c]);
      check("data", obs_data, e.data);
      check("enables", 32'({ramWEN, ramREN}), e.wr ? 32'd2 : 32'd1);
      $display("txn %s%0d %s addr=%h data=%h", is_d ? "d" : "i", c,
               e.wr ? "wr" : "rd", ramaddr, obs_data);
   endtask

   always @(negedge CLK) begin
      if (nRST) begin
         for (int c = 0; c < CPUS; c++) begin
            if (!dwait[c]) complete(1'b1, c);
            if (!iwait[c]) complete(1'b0, c);
         end
      end
   end

   task automatic wait_done(input logic is_d, input int c);
      int   n;
      logic done;
      n    = 0;
      done = 1'b0;
      while (!done && n < BUDGET) begin
         @(negedge CLK);
         n++;
         done = is_d ? !dwait[c] : !iwait[c];
      end
      check(is_d ? "d_timeout" : "i_timeout", 32'(done), 32'd1);
   endtask

   task automatic d_req(input int c, input word_t a, input int words);
      dREN[c]  = 1'b1;
      daddr[c] = a;
      for (int w = 0; w < words; w++) begin
         wait_done(1'b1, c);
         @(posedge CLK);
         #1;
         if (w + 1 < words) daddr[c] = a + 32'(4 * (w + 1));
      end
      dREN[c] = 1'b0;
   endtask

   task automatic i_req(input int c, input word_t a, input int words);
      iREN[c]  = 1'b1;
      iaddr[c] = a;
      for (int w = 0; w < words; w++) begin
         wait_done(1'b0, c);
         @(posedge CLK);
         #1;
         if (w + 1 < words) iaddr[c] = a + 32'(4 * (w + 1));
      end
      iREN[c] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < BUDGET) begin
         @(posedge CLK);
         n++;
      end
      check("drain", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic gap();
      repeat (2) @(posedge CLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      iREN = '0; dREN = '0; dWEN = '0;
      iaddr = '0; daddr = '0; dstore = '0;
      lat = 0; use_ovr = 1'b0;
      nRST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_ren", 32'(ramREN), 32'd0);
      check("rst_wen", 32'(ramWEN), 32'd0);
      check("rst_addr", ramaddr, 32'd0);
      check("rst_store", ramstore, 32'd0);
      check("rst_waits", 32'({iwait, dwait}), 32'hF);
      nRST = 1'b1;
      gap();

      // Single dcache read with two BUSY cycles.
      lat = 2; use_ovr = 1'b1;
      sb_q.push_back(mk(1'b1, 1'b0, 0, 32'h100, 32'hDEAD_BEEF));
      dREN[0] = 1'b1; daddr[0] = 32'h100;
      @(negedge CLK); check("t1_c0_ren", 32'(ramREN), 32'd0);
      @(negedge CLK); check("t1_c1_ren", 32'(ramREN), 32'd1);
                      check("t1_c1_addr", ramaddr, 32'h100);
                      check("t1_c1_dwait", 32'(dwait), 32'h3);
      @(negedge CLK); check("t1_c2_dwait", 32'(dwait), 32'h3);
      @(negedge CLK); check("t1_c3_dwait", 32'(dwait), 32'h2);
                      check("t1_c3_iwait", 32'(iwait), 32'h3);
                      check("t1_c3_dload", dload[0], 32'hDEAD_BEEF);
      @(posedge CLK); #1; dREN[0] = 1'b0;
      @(negedge CLK); check("t1_drop_ren", 32'(ramREN), 32'd0);
      use_ovr = 1'b0;
      gap();

      // Contention: dcache 1 beats icache 0.
      lat = 1;
      sb_q.push_back(mk(1'b1, 1'b0, 1, 32'h140, rd_data(32'h140)));
      sb_q.push_back(mk(1'b0, 1'b0, 0, 32'h180, rd_data(32'h180)));
      fork
         d_req(1, 32'h140, 1);
         i_req(0, 32'h180, 1);
      join
      gap();

      // Block lock: two-word dcache fetch not interleaved with icache 1.
      sb_q.push_back(mk(1'b1, 1'b0, 0, 32'h200, rd_data(32'h200)));
      sb_q.push_back(mk(1'b1, 1'b0, 0, 32'h204, rd_data(32'h204)));
      sb_q.push_back(mk(1'b0, 1'b0, 1, 32'h600, rd_data(32'h600)));
      fork
         d_req(0, 32'h200, 2);
         i_req(1, 32'h600, 1);
      join
      gap();

      // Round-robin with zero-latency RAM: two words per core, alternating.
      lat = 0;
      for (int k = 0; k < 4; k++) begin
         sb_q.push_back(mk(1'b1, 1'b0, k % 2, (k % 2 == 0) ? 32'h400 : 32'h500,
                           rd_data((k % 2 == 0) ? 32'h400 : 32'h500)));
         sb_q.push_back(mk(1'b1, 1'b0, k % 2, (k % 2 == 0) ? 32'h400 : 32'h500,
                           rd_data((k % 2 == 0) ? 32'h400 : 32'h500)));
      end
      dREN = '1; daddr[0] = 32'h400; daddr[1] = 32'h500;
      drain();
      #1; dREN = '0;
      gap();

      // Write wins over read on the same dcache.
      sb_q.push_back(mk(1'b1, 1'b1, 0, 32'h300, 32'h1234_5678));
      dREN[0] = 1'b1; dWEN[0] = 1'b1; daddr[0] = 32'h300; dstore[0] = 32'h1234_5678;
      @(negedge CLK);
      @(negedge CLK); check("wr_wen", 32'(ramWEN), 32'd1);
                      check("wr_ren", 32'(ramREN), 32'd0);
                      check("wr_store", ramstore, 32'h1234_5678);
                      check("wr_addr", ramaddr, 32'h300);
      @(posedge CLK); #1; dREN[0] = 1'b0; dWEN[0] = 1'b0;
      gap();

      // Reset mid-grant, then both cores: core 0 must win.
      lat = 5;
      dREN[1] = 1'b1; daddr[1] = 32'h700;
      n = 0;
      do begin @(negedge CLK); n++; end while (!ramREN && n < 10);
      check("rst_pre_ren", 32'(ramREN), 32'd1);
      #2 nRST = 1'b0;
      #1;
      check("rst_mid_ren", 32'(ramREN), 32'd0);
      check("rst_mid_waits", 32'({iwait, dwait}), 32'hF);
      dREN = '0;
      @(posedge CLK); #1; nRST = 1'b1;
      gap();
      lat = 1;
      sb_q.push_back(mk(1'b1, 1'b0, 0, 32'h800, rd_data(32'h800)));
      sb_q.push_back(mk(1'b1, 1'b0, 1, 32'h900, rd_data(32'h900)));
      fork
         d_req(0, 32'h800, 1);
         d_req(1, 32'h900, 1);
      join
      gap();

      check("sb_left", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
